fifo_stream_reader: RTL and testbench
=====================================

Name: fifo_stream_reader

Overview:
Read-side consumer for the team's synchronous FIFO. It drives the FIFO read enable and converts the FIFO's registered read data into a valid/ready output stream. It prefetches into a 2-entry output buffer so full throughput (1 word/cycle) survives the FIFO's 1-cycle read latency and downstream backpressure. It sits between the FIFO data_out/empty/r_en pins and any stream consumer.

Parameters:
DATA_W, 8, width of FIFO word and output stream data
CNT_W, 16, width of statistics counters (used only with the optional feature)

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  asynchronous, active-high reset
en  input  1  1 = allowed to issue FIFO reads; 0 = stop issuing reads while buffered data still drains
fifo_empty  input  1  FIFO empty flag
fifo_data_out  input  DATA_W  FIFO read data, valid the cycle after fifo_r_en=1
fifo_r_en  output  1  FIFO read enable (one pop per high cycle)
m_valid  output  1  output word valid
m_ready  input  1  consumer accepts the word when m_valid & m_ready
m_data  output  DATA_W  output word
rd_count  output  CNT_W  optional feature only: words delivered
stall_count  output  CNT_W  optional feature only: cycles with m_valid=1 and m_ready=0

Behaviour:
- Reset (async assert, sync release): fifo_r_en=0, m_valid=0, m_data=0, buffer empty, in-flight flag 0, counters 0. Reset mid-burst discards buffered and in-flight words. A word popped the cycle before reset is lost; the bench accounts for it.
- FIFO read latency is fixed at 1 cycle. fifo_r_en=1 at cycle t means fifo_data_out is captured at the rising edge ending cycle t+1. The in-flight flag is set to the registered fifo_r_en.
- Buffer: 2 entries, FIFO order. Occupancy FSM has states EMPTY, ONE, TWO.
  - push = in-flight capture; pop = m_valid & m_ready.
  - EMPTY: push -> ONE.
  - ONE: push & !pop -> TWO; pop & !push -> EMPTY; push & pop -> ONE.
  - TWO: pop -> ONE. Push in TWO without pop is impossible by the credit rule; the checker flags it as an error.
- m_valid = (state != EMPTY). m_data = head entry; it is registered, with no combinational path from fifo_data_out.
- Read issue (combinational): fifo_r_en = en & !fifo_empty & (occ + inflight - pop < 2), using 2-bit unsigned arithmetic. This never overflows the buffer and never reads an empty FIFO.
- Latency: first word into an idle, empty FIFO with m_ready=1 and en=1. fifo_empty falls in cycle t -> fifo_r_en in t -> capture at end of t+1 -> m_valid=1 in t+2.
- Throughput: with m_ready held at 1 and the FIFO non-empty, one word per cycle, no bubbles.
- Backpressure: with m_ready=0, at most 2 words are held. fifo_r_en stays 0 once occ + inflight = 2.
- Simultaneous push and pop in ONE: the head advances to the pushed word, and the state stays ONE.
- en deasserted: no new fifo_r_en. The in-flight word is still captured, and the buffer drains normally.
- fifo_empty rising while a read is in flight: the in-flight word is still valid and is captured.

Optional Feature:
Macro FIFO_STREAM_READER_STATS_EN.
- Defined: rd_count increments on each pop; stall_count increments each cycle with m_valid & !m_ready. Both saturate at all-ones and clear on rst.
- Undefined: both ports are still present and tied to 0; no counter flops are built.

Decomposition:
- Package fifo_stream_reader_pkg holds:
  - typedef enum logic [1:0] occ_state_t {EMPTY, ONE, TWO};
  - localparam BUF_DEPTH = 2;
  - a saturating-increment function used by the statistics counters.
- One sub-module, fifo_stream_reader_buf, holds the 2-entry register buffer plus the occupancy FSM. Its ports are push, push_data, pop, valid, head_data and occ.
- The top holds the credit logic, the in-flight flag and the optional counters.

Test Plan:
- Reset, then FIFO pre-filled with 0x11,0x22,0x33, m_ready=1, en=1 -> fifo_r_en high 3 consecutive cycles; m_data 0x11,0x22,0x33 on 3 consecutive cycles starting 2 cycles after the first fifo_r_en; fifo never read while empty.
- FIFO holds 0xA0..0xA7, m_ready=0 for 10 cycles then 1 -> exactly 2 pops before the stall; m_valid=1 holding 0xA0 throughout the stall; then 0xA0..0xA7 in order with no gaps or duplicates.
- Random m_ready (50%), 256 words 0x00..0xFF -> output order exact; buffer occupancy never exceeds 2; no read on fifo_empty=1.
- en dropped for 5 cycles mid-stream with m_ready=1 -> fifo_r_en=0 during that window; the in-flight word and buffered words still delivered; resumes 1 word/cycle when en returns.
- rst asserted asynchronously mid-stream with 2 words buffered -> m_valid=0 and fifo_r_en=0 immediately; after release, the next delivered word is the FIFO's current head.
- With FIFO_STREAM_READER_STATS_EN, 4 words delivered and 3 stall cycles -> rd_count=4, stall_count=3; with the macro undefined, both read 0.

Source files
------------

// File: rtl/fifo_stream_reader_pkg.sv
// Shared types and helpers for the FIFO stream reader.
//   occ_state_t : occupancy states of the 2-entry output buffer
//   BUF_DEPTH   : number of words the output buffer can hold
//   sat_inc     : saturating increment for a counter of width w (w <= 64)
package fifo_stream_reader_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_state_t;

    localparam int unsigned BUF_DEPTH = 2;

    // Increment v, holding at the all-ones value of a w-bit counter.
    function automatic logic [63:0] sat_inc(input logic [63:0] v, input int unsigned w);
        logic [63:0] max_v;
        max_v = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        return (v >= max_v) ? v : v + 64'd1;
    endfunction

endpackage

// File: rtl/fifo_stream_reader_buf.sv
// Two-entry FIFO-ordered register buffer with occupancy FSM.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   push       : write push_data into the buffer this cycle
//   push_data  : word to store
//   pop        : consumer took the head word this cycle
//   valid      : buffer holds at least one word
//   head_data  : oldest word (registered)
//   occ        : current occupancy, 0..2
module fifo_stream_reader_buf
    import fifo_stream_reader_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic              valid,
    output logic [DATA_W-1:0] head_data,
    output logic [1:0]        occ
);

    occ_state_t        state_q, state_d;
    logic [DATA_W-1:0] head_q, head_d;
    logic [DATA_W-1:0] tail_q, tail_d;

    // State and storage registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

    // Next state and storage updates; the head always holds the oldest word.
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        case (state_q)
            EMPTY: begin
                if (push) begin
                    head_d  = push_data;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (push && pop) begin
                    head_d = push_data;
                end else if (push) begin
                    tail_d  = push_data;
                    state_d = TWO;
                end else if (pop) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                if (pop) begin
                    head_d  = tail_q;
                    state_d = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    assign valid     = (state_q != EMPTY);
    assign head_data = head_q;

    always_comb begin
        occ = 2'd0;
        case (state_q)
            ONE:     occ = 2'd1;
            TWO:     occ = 2'd2;
            default: occ = 2'd0;
        endcase
    end

`ifndef SYNTHESIS
    // The read credit logic upstream must never push into a full buffer.
    always @(posedge clk) begin
        if (!rst) begin
            assert (!(state_q == TWO && push && !pop))
            else $error("fifo_stream_reader_buf: push into full buffer");
        end
    end
`endif

endmodule

// File: rtl/fifo_stream_reader.sv
// Read-side consumer for the synchronous FIFO: issues fifo_r_en under a
// credit limit and turns the 1-cycle-latency read data into a valid/ready
// stream through a 2-entry prefetch buffer.
// Optional statistics counters: define FIFO_STREAM_READER_STATS_EN.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   en              : permit new FIFO reads (buffered words still drain)
//   fifo_empty      : FIFO empty flag
//   fifo_data_out   : FIFO read data, valid the cycle after fifo_r_en
//   fifo_r_en       : FIFO read enable (combinational)
//   m_valid/m_ready : output stream handshake
//   m_data          : output word (registered)
//   rd_count        : words delivered (stats build only, else 0)
//   stall_count     : cycles with m_valid & !m_ready (stats build only, else 0)
module fifo_stream_reader
    import fifo_stream_reader_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_data_out,
    output logic              fifo_r_en,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic [CNT_W-1:0]  rd_count,
    output logic [CNT_W-1:0]  stall_count
);

    logic       inflight_q;
    logic       pop_c;
    logic [1:0] occ;
    logic [1:0] credit_used_c;

    assign pop_c = m_valid & m_ready;

    // Words already committed to the buffer once this cycle's pop retires;
    // a new read is only issued while that leaves a free slot.
    assign credit_used_c = occ + 2'(inflight_q) - 2'(pop_c);
    assign fifo_r_en     = ~rst & en & ~fifo_empty & (credit_used_c < 2'(BUF_DEPTH));

    // Read data arrives one cycle after the enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= fifo_r_en;
        end
    end

    fifo_stream_reader_buf #(
        .DATA_W (DATA_W)
    ) u_out_buf (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight_q),
        .push_data (fifo_data_out),
        .pop       (pop_c),
        .valid     (m_valid),
        .head_data (m_data),
        .occ       (occ)
    );

`ifdef FIFO_STREAM_READER_STATS_EN
    logic [CNT_W-1:0] rd_count_q;
    logic [CNT_W-1:0] stall_count_q;

    // Delivered-word and backpressure-cycle counters, saturating.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_count_q    <= '0;
            stall_count_q <= '0;
        end else begin
            if (pop_c) begin
                rd_count_q <= CNT_W'(sat_inc(64'(rd_count_q), CNT_W));
            end
            if (m_valid && !m_ready) begin
                stall_count_q <= CNT_W'(sat_inc(64'(stall_count_q), CNT_W));
            end
        end
    end

    assign rd_count    = rd_count_q;
    assign stall_count = stall_count_q;
`else
    assign rd_count    = '0;
    assign stall_count = '0;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Testbench for fifo_stream_reader: a queue-based FIFO stub drives the
// reader, and a transaction-level model predicts every output cycle.
module tb_fifo_stream_reader;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned CNT_W  = 16;
`ifdef FIFO_STREAM_READER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic              clk;
    logic              rst;
    logic              en;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_data_out;
    logic              fifo_r_en;
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;
    logic [CNT_W-1:0]  rd_count;
    logic [CNT_W-1:0]  stall_count;

    fifo_stream_reader #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .fifo_empty    (fifo_empty),
        .fifo_data_out (fifo_data_out),
        .fifo_r_en     (fifo_r_en),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_data        (m_data),
        .rd_count      (rd_count),
        .stall_count   (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // A popped word and the first cycle it may appear on the output.
    typedef struct {
        logic [7:0] data;
        int         avail;
    } ent_t;

    logic [7:0] fq[$];      // words still inside the FIFO
    ent_t       exp_q[$];   // words popped but not yet delivered

    int         cyc;
    int         n_checks;
    int         n_fail;
    int         n_dlv;
    int         n_ren;
    int         first_ren;
    int         first_dlv;
    int         last_dlv;
    int         rd_m;
    int         stall_m;
    bit         catch_next;
    logic [7:0] caught;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock cycle: called at a falling edge with inputs already set.
    task automatic step();
        bit         ev;
        bit         dl;
        bit         exp_ren;
        bit         r;
        logic [7:0] d;
        #1;
        ev      = (exp_q.size() > 0) && (exp_q[0].avail <= cyc);
        dl      = ev && m_ready;
        exp_ren = !rst && en && (fq.size() > 0) && ((exp_q.size() - (dl ? 1 : 0)) < 2);
        check_eq("m_valid", 32'(m_valid), 32'(ev));
        if (ev) check_eq("m_data", 32'(m_data), 32'(exp_q[0].data));
        check_eq("fifo_r_en", 32'(fifo_r_en), 32'(exp_ren));
        check_eq("rd_on_empty", 32'(fifo_r_en & fifo_empty), 32'd0);
        if (dl) begin
            void'(exp_q.pop_front());
            if (first_dlv < 0) first_dlv = cyc;
            last_dlv = cyc;
            n_dlv++;
            if (rd_m < 65535) rd_m++;
            if (catch_next) begin
                caught     = m_data;
                catch_next = 1'b0;
            end
        end
        if (ev && !m_ready && stall_m < 65535) stall_m++;
        r = fifo_r_en && !fifo_empty;
        if (r && first_ren < 0) first_ren = cyc;
        @(negedge clk);
        cyc++;
        if (r) begin
            d             = fq.pop_front();
            fifo_data_out = d;
            exp_q.push_back('{data: d, avail: cyc + 1});
            n_ren++;
        end
        fifo_empty = (fq.size() == 0);
    endtask

    task automatic drain(input string tag, input int target, input int budget);
        for (int i = 0; i < budget && n_dlv < target; i++) step();
        check_eq(tag, 32'(n_dlv), 32'(target));
    endtask

    // Asynchronous reset pulse mid-cycle; returns aligned to a falling edge.
    task automatic do_reset();
        #2 rst = 1'b1;
        #1;
        check_eq("rst_m_valid", 32'(m_valid), 32'd0);
        check_eq("rst_fifo_r_en", 32'(fifo_r_en), 32'd0);
        exp_q.delete();
        rd_m    = 0;
        stall_m = 0;
        @(negedge clk);
        cyc++;
        check_eq("rst_m_data", 32'(m_data), 32'd0);
        check_eq("rst_rd_count", 32'(rd_count), 32'd0);
        check_eq("rst_stall_count", 32'(stall_count), 32'd0);
        rst = 1'b0;
    endtask

    task automatic push_words(input logic [7:0] start, input int n);
        for (int i = 0; i < n; i++) fq.push_back(8'(start + 8'(i)));
        fifo_empty = (fq.size() == 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         base;
        int         n0;
        logic [7:0] exp_head;

        rst           = 1'b1;
        en            = 1'b0;
        m_ready       = 1'b0;
        fifo_empty    = 1'b1;
        fifo_data_out = '0;
        cyc           = 0;
        n_checks      = 0;
        n_fail        = 0;
        n_dlv         = 0;
        n_ren         = 0;
        rd_m          = 0;
        stall_m       = 0;
        first_ren     = -1;
        first_dlv     = -1;
        last_dlv      = -1;
        catch_next    = 1'b0;
        caught        = '0;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check_eq("reset_m_valid", 32'(m_valid), 32'd0);
        check_eq("reset_m_data", 32'(m_data), 32'd0);
        check_eq("reset_fifo_r_en", 32'(fifo_r_en), 32'd0);
        check_eq("reset_rd_count", 32'(rd_count), 32'd0);
        check_eq("reset_stall_count", 32'(stall_count), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        cyc = 0;

        // Three pre-filled words, consumer always ready
        push_words(8'h11, 0);
        fq.push_back(8'h11);
        fq.push_back(8'h22);
        fq.push_back(8'h33);
        fifo_empty = 1'b0;
        en         = 1'b1;
        m_ready    = 1'b1;
        base       = n_dlv;
        drain("t1_delivered", base + 3, 20);
        repeat (2) step();
        check_eq("t1_pops", 32'(n_ren), 32'd3);
        check_eq("t1_latency", 32'(first_dlv - first_ren), 32'd2);
        check_eq("t1_burst", 32'(last_dlv - first_dlv), 32'd2);

        // Backpressure: consumer stalls 10 cycles
        n_ren   = 0;
        m_ready = 1'b0;
        push_words(8'hA0, 8);
        repeat (10) step();
        check_eq("t2_stall_pops", 32'(n_ren), 32'd2);
        check_eq("t2_stall_valid", 32'(m_valid), 32'd1);
        check_eq("t2_stall_head", 32'(m_data), 32'hA0);
        m_ready = 1'b1;
        base    = n_dlv;
        drain("t2_delivered", base + 8, 40);
        check_eq("t2_total_pops", 32'(n_ren), 32'd8);

        // Random backpressure over 256 words
        push_words(8'h00, 256);
        base = n_dlv;
        for (int i = 0; i < 3000 && n_dlv < base + 256; i++) begin
            m_ready = 1'($urandom_range(0, 1));
            step();
        end
        check_eq("t3_delivered", 32'(n_dlv - base), 32'd256);
        check_eq("t3_rd_count", 32'(rd_count), STATS ? 32'(rd_m) : 32'd0);
        check_eq("t3_stall_count", 32'(stall_count), STATS ? 32'(stall_m) : 32'd0);

        // Read enable dropped for 5 cycles mid-stream
        m_ready = 1'b1;
        push_words(8'h40, 20);
        base = n_dlv;
        repeat (6) step();
        n0 = n_ren;
        en = 1'b0;
        repeat (5) step();
        check_eq("t4_en_off_pops", 32'(n_ren - n0), 32'd0);
        en = 1'b1;
        drain("t4_delivered", base + 20, 60);

        // Asynchronous reset with two words buffered
        m_ready = 1'b0;
        push_words(8'h60, 10);
        repeat (4) step();
        check_eq("t5_buffered_valid", 32'(m_valid), 32'd1);
        do_reset();
        exp_head   = fq[0];
        n0         = fq.size();
        m_ready    = 1'b1;
        catch_next = 1'b1;
        base       = n_dlv;
        drain("t5_delivered", base + n0, 40);
        check_eq("t5_first_after_rst", 32'(caught), 32'(exp_head));

        // Statistics: 4 deliveries, 3 stall cycles
        do_reset();
        m_ready = 1'b0;
        push_words(8'hC0, 4);
        for (int i = 0; i < 50 && stall_m < 3; i++) step();
        m_ready = 1'b1;
        base    = n_dlv;
        drain("t6_delivered", base + 4, 30);
        repeat (2) step();
        check_eq("t6_rd_count", 32'(rd_count), STATS ? 32'd4 : 32'd0);
        check_eq("t6_stall_count", 32'(stall_count), STATS ? 32'd3 : 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
